// File: rtl/ami_rd_cmd.sv
// AXI read-command engine: splits a byte-range read into 4KB-safe INCR bursts and merges
// the returned beats into one command-level stream. Define AMI_RD_WDOG_EN for the response watchdog.
module ami_rd_cmd #(
    parameter int unsigned AXI_DW   = 128,
    parameter int unsigned AXI_AW   = 32,
    parameter int unsigned AXI_IW   = 8,
    parameter int unsigned AXI_LW   = 8,
    parameter int unsigned AXI_SW   = 3,
    parameter int unsigned LENW     = 24,
    parameter int unsigned BL       = 16,
    parameter int unsigned MAX_OST  = 4,
    parameter int unsigned RID_VAL  = 0,
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [AXI_AW-1:0] cmd_addr,
    input  logic [LENW-1:0]   cmd_bytes,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [AXI_IW-1:0] usr_arid,
    output logic [AXI_AW-1:0] usr_araddr,
    output logic [AXI_LW-1:0] usr_arlen,
    output logic [AXI_SW-1:0] usr_arsize,
    output logic [1:0]        usr_arburst,
    output logic              usr_arvalid,
    input  logic              usr_arready,
    input  logic [AXI_IW-1:0] usr_rid,
    input  logic [AXI_DW-1:0] usr_rdata,
    input  logic [1:0]        usr_rresp,
    input  logic              usr_rlast,
    input  logic              usr_rvalid,
    output logic              usr_rready,
    output logic [AXI_DW-1:0] dout_data,
    output logic              dout_last,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done,
    output logic              err,
    output logic              busy
);
    localparam int unsigned BPB   = AXI_DW / 8;
    localparam int unsigned SHIFT = $clog2(BPB);
    localparam int unsigned OW    = $clog2(MAX_OST + 1);
    localparam int unsigned PW    = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [AXI_AW-1:0]   addr_q, addr_d;
    logic [LENW-1:0]     rem_q, rem_d;
    logic [AXI_AW-1:0]   araddr_q, araddr_d;
    logic [AXI_LW-1:0]   arlen_q, arlen_d;
    logic                arvalid_q, arvalid_d;
    logic [OW-1:0]       ost_q, ost_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AXI_LW-1:0]   fifo_q [MAX_OST];
    logic [AXI_LW-1:0]   fifo_d [MAX_OST];
    logic [AXI_LW-1:0]   beat_cnt_q, beat_cnt_d;
    logic                sticky_q, sticky_d;
    logic                done_q, done_d, err_q, err_d;

    logic                r_active, r_hs, r_pop, ar_hs, exp_last, drop;
    logic [LENW:0]       nb;
    logic [LENW-1:0]     ar_beats;
    logic [12:0]         room_beats, beats_c;
    logic                unused_rid;

    assign unused_rid = ^usr_rid;

    assign r_active  = (state_q == StIssue) || (state_q == StDrain);
    assign r_hs      = r_active && usr_rvalid && dout_ready;
    assign r_pop     = r_hs && usr_rlast && (ost_q != '0);
    assign ar_hs     = arvalid_q && usr_arready;
    assign exp_last  = (beat_cnt_q == fifo_q[rd_ptr_q]);
    assign ar_beats  = LENW'(arlen_q) + LENW'(1);
    assign nb        = ({1'b0, cmd_bytes} + (LENW + 1)'(BPB - 1)) >> SHIFT;

    assign usr_arid    = AXI_IW'(RID_VAL);
    assign usr_araddr  = araddr_q;
    assign usr_arlen   = arlen_q;
    assign usr_arsize  = AXI_SW'(SHIFT);
    assign usr_arburst = 2'b01;
    assign usr_arvalid = arvalid_q;
    assign usr_rready  = drop ? 1'b1 : (r_active && dout_ready);
    assign dout_data   = usr_rdata;
    assign dout_valid  = !drop && r_active && usr_rvalid;
    assign dout_last   = r_active && usr_rlast && (ost_q == OW'(1)) && (rem_q == '0);
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = (state_q != StIdle);

    // Burst size: capped by BL, what is left, and the room before the next 4KB page.
    always_comb begin
        room_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SHIFT;
        beats_c    = 13'(BL);
        if (rem_q < LENW'(beats_c)) beats_c = 13'(rem_q);
        if (room_beats < beats_c) beats_c = room_beats;
    end

`ifdef AMI_RD_WDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYC + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          drop_q, drop_d;
    assign drop = drop_q;
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arvalid_d  = arvalid_q;
        ost_d      = ost_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_d     = fifo_q;
        beat_cnt_d = beat_cnt_q;
        sticky_d   = sticky_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cmd_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~AXI_AW'(BPB - 1);
                    rem_d   = LENW'(nb);
                    state_d = (nb == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (arvalid_q) begin
                    if (usr_arready) begin
                        arvalid_d = 1'b0;
                        addr_d    = addr_q + ((AXI_AW'(arlen_q) + AXI_AW'(1)) << SHIFT);
                        rem_d     = rem_q - ar_beats;
                        if (rem_q == ar_beats) state_d = StDrain;
                    end
                end else if ((rem_q != '0) && (ost_q < OW'(MAX_OST))) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q;
                    arlen_d   = AXI_LW'(beats_c - 13'd1);
                end
            end
            StDrain: begin
                if (r_pop && (ost_q == OW'(1))) state_d = StDone;
            end
            StDone: begin
                done_d   = 1'b1;
                err_d    = sticky_q;
                sticky_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (ar_hs) begin
            fifo_d[wr_ptr_q] = arlen_q;
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OST - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (r_hs) begin
            if ((usr_rresp != 2'b00) || (usr_rlast != exp_last) || (ost_q == '0)) sticky_d = 1'b1;
            beat_cnt_d = usr_rlast ? '0 : beat_cnt_q + AXI_LW'(1);
        end
        if (r_pop) rd_ptr_d = (rd_ptr_q == PW'(MAX_OST - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (ar_hs && !r_pop) ost_d = ost_q + OW'(1);
        else if (!ar_hs && r_pop) ost_d = ost_q - OW'(1);

`ifdef AMI_RD_WDOG_EN
        drop_d = drop_q;
        wdog_d = '0;
        if ((state_q == StIdle) && cmd_valid) drop_d = 1'b0;
        if (r_active && (ost_q != '0) && !r_hs) wdog_d = wdog_q + WW'(1);
        // Timeout abandons the command; late beats are swallowed until the next accept.
        if (r_active && (wdog_q == WW'(WDOG_CYC))) begin
            state_d    = StDone;
            sticky_d   = 1'b1;
            ost_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            beat_cnt_d = '0;
            rem_d      = '0;
            arvalid_d  = 1'b0;
            drop_d     = 1'b1;
            wdog_d     = '0;
        end
`endif
    end

`ifdef AMI_RD_WDOG_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wdog_q <= '0;
            drop_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            drop_q <= drop_d;
        end
    end
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arvalid_q  <= 1'b0;
            ost_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_q     <= '{default: '0};
            beat_cnt_q <= '0;
            sticky_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arvalid_q  <= arvalid_d;
            ost_q      <= ost_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
            beat_cnt_q <= beat_cnt_d;
            sticky_q   <= sticky_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule
